// File: rtl/sample_buffer.sv
// 16 x 4-bit sample buffer: key-driven writes, drain reads into a running sum.
// Optional ACC_SAT_EN macro makes disp_out saturate instead of wrapping.
module sample_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 4,
  parameter int ACC_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_wr_n,
  input  logic                  key_rd_n,
  input  logic                  clr,
  input  logic [DATA_W-1:0]     sw,
  output logic [DEPTH_LOG2-1:0] count_w,
  output logic [DEPTH_LOG2-1:0] count_r,
  output logic [DATA_W-1:0]     ram_out,
  output logic [ACC_W-1:0]      disp_out,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   OCC_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   OCC_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_ACC} state_t;

  state_t                state_q, state_d;
  logic                  key_wr_q, key_rd_q;
  logic                  wr_req, rd_req;
  logic                  pend_wr_q, pend_wr_d;
  logic                  pend_rd_q, pend_rd_d;
  logic [DEPTH_LOG2-1:0] count_w_q, count_w_d;
  logic [DEPTH_LOG2-1:0] count_r_q, count_r_d;
  logic [DEPTH_LOG2:0]   occ_q, occ_d;
  logic [DATA_W-1:0]     ram_out_q, ram_out_d;
  logic [ACC_W-1:0]      disp_q, disp_d;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DATA_W-1:0]     rd_data_q;

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0]  acc,
                                                input logic [DATA_W-1:0] smp);
`ifdef ACC_SAT_EN
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W+1-DATA_W){1'b0}}, smp};
    acc_add = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_add = acc + {{(ACC_W-DATA_W){1'b0}}, smp};
`endif
  endfunction

  // A request is a released-to-pressed transition seen at the clock edge.
  assign wr_req = key_wr_q & ~key_wr_n;
  assign rd_req = key_rd_q & ~key_rd_n;

  assign full  = (occ_q == OCC_FULL);
  assign empty = (occ_q == '0);

  always_comb begin
    state_d   = state_q;
    pend_wr_d = pend_wr_q;
    pend_rd_d = pend_rd_q;
    count_w_d = count_w_q;
    count_r_d = count_r_q;
    occ_d     = occ_q;
    ram_out_d = ram_out_q;
    disp_d    = disp_q;
    mem_we    = 1'b0;
    if (clr) begin
      state_d   = IDLE;
      pend_wr_d = 1'b0;
      pend_rd_d = 1'b0;
      count_w_d = '0;
      count_r_d = '0;
      occ_d     = '0;
      ram_out_d = '0;
      disp_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_req || pend_wr_q) begin
            pend_wr_d = 1'b0;
            if (!full) begin
              mem_we    = 1'b1;
              count_w_d = count_w_q + PTR_ONE;
              occ_d     = occ_q + OCC_ONE;
            end
            // A read arriving alongside a write waits for the next IDLE cycle.
            if (rd_req) pend_rd_d = 1'b1;
          end else if (rd_req || pend_rd_q) begin
            pend_rd_d = 1'b0;
            if (!empty) state_d = RD_ADDR;
          end
        end
        RD_ADDR: begin
          ram_out_d = rd_data_q;
          count_r_d = count_r_q + PTR_ONE;
          occ_d     = occ_q - OCC_ONE;
          state_d   = RD_ACC;
          if (wr_req) pend_wr_d = 1'b1;
          if (rd_req) pend_rd_d = 1'b1;
        end
        RD_ACC: begin
          disp_d  = acc_add(disp_q, ram_out_q);
          state_d = IDLE;
          if (wr_req) pend_wr_d = 1'b1;
          if (rd_req) pend_rd_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      key_wr_q  <= 1'b1;
      key_rd_q  <= 1'b1;
      pend_wr_q <= 1'b0;
      pend_rd_q <= 1'b0;
      count_w_q <= '0;
      count_r_q <= '0;
      occ_q     <= '0;
      ram_out_q <= '0;
      disp_q    <= '0;
    end else begin
      state_q   <= state_d;
      key_wr_q  <= key_wr_n;
      key_rd_q  <= key_rd_n;
      pend_wr_q <= pend_wr_d;
      pend_rd_q <= pend_rd_d;
      count_w_q <= count_w_d;
      count_r_q <= count_r_d;
      occ_q     <= occ_d;
      ram_out_q <= ram_out_d;
      disp_q    <= disp_d;
    end
  end

  // Storage is not reset; the read port registers mem[count_r] every cycle.
  always_ff @(posedge clk) begin
    if (mem_we) mem[count_w_q] <= sw;
    rd_data_q <= mem[count_r_q];
  end

  assign count_w  = count_w_q;
  assign count_r  = count_r_q;
  assign ram_out  = ram_out_q;
  assign disp_out = disp_q;

endmodule

// File: tb/tb_sample_buffer.sv
// Directed self-checking bench for sample_buffer; expected values hand-computed.
module tb_sample_buffer;

  logic        clk;
  logic        rst_n;
  logic        key_wr_n;
  logic        key_rd_n;
  logic        clr;
  logic [3:0]  sw;
  logic [3:0]  count_w;
  logic [3:0]  count_r;
  logic [3:0]  ram_out;
  logic [11:0] disp_out;
  logic        full;
  logic        empty;

  int vectors;
  int miscompares;

  sample_buffer #(.DEPTH_LOG2(4), .DATA_W(4), .ACC_W(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_wr_n (key_wr_n),
    .key_rd_n (key_rd_n),
    .clr      (clr),
    .sw       (sw),
    .count_w  (count_w),
    .count_r  (count_r),
    .ram_out  (ram_out),
    .disp_out (disp_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  task automatic do_write(input logic [3:0] v);
    @(negedge clk);
    sw = v;
    key_wr_n = 1'b0;
    @(negedge clk);
    key_wr_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns on the falling edge after disp_out has been updated.
  task automatic do_read();
    @(negedge clk);
    key_rd_n = 1'b0;
    @(negedge clk);
    key_rd_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({count_w, count_r, ram_out, disp_out, empty, full} !== {4'h0, 4'h0, 4'h0, 12'h000, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got cw=%h cr=%h ram=%h disp=%h e=%b f=%b, want all 0 e=1 f=0",
               count_w, count_r, ram_out, disp_out, empty, full);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({count_w, count_r, ram_out, disp_out, empty, full} !== {4'h0, 4'h0, 4'h0, 12'h000, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL idle_after_reset: got cw=%h cr=%h ram=%h disp=%h e=%b f=%b, want all 0 e=1 f=0",
               count_w, count_r, ram_out, disp_out, empty, full);
    end
  endtask

  task automatic test_basic();
    do_write(4'h3);
    do_write(4'h5);
    do_write(4'h9);
    vectors++;
    if (count_w !== 4'd3 || empty !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_writes: got cw=%0d empty=%b, want cw=3 empty=0", count_w, empty);
    end
    // First read traced edge by edge for latency.
    @(negedge clk);
    key_rd_n = 1'b0;
    @(negedge clk);
    key_rd_n = 1'b1;
    vectors++;
    if (ram_out !== 4'h0) begin
      miscompares++;
      $display("FAIL read_latency_early: got ram=%h, want 0", ram_out);
    end
    @(negedge clk);
    vectors++;
    if (ram_out !== 4'h3 || disp_out !== 12'h000) begin
      miscompares++;
      $display("FAIL read_latency_ram: got ram=%h disp=%h, want ram=3 disp=000", ram_out, disp_out);
    end
    @(negedge clk);
    vectors++;
    if (disp_out !== 12'h003) begin
      miscompares++;
      $display("FAIL read_latency_disp: got disp=%h, want 003", disp_out);
    end
    do_read();
    vectors++;
    if (ram_out !== 4'h5 || disp_out !== 12'h008) begin
      miscompares++;
      $display("FAIL basic_read2: got ram=%h disp=%h, want ram=5 disp=008", ram_out, disp_out);
    end
    do_read();
    vectors++;
    if (ram_out !== 4'h9 || disp_out !== 12'h011 || count_r !== 4'd3 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_read3: got ram=%h disp=%h cr=%0d e=%b, want ram=9 disp=011 cr=3 e=1",
               ram_out, disp_out, count_r, empty);
    end
  endtask

  task automatic test_full_wrap();
    do_clr();
    vectors++;
    if (count_w !== 4'd0 || count_r !== 4'd0 || disp_out !== 12'h000 || ram_out !== 4'h0) begin
      miscompares++;
      $display("FAIL clr_zero: got cw=%0d cr=%0d disp=%h ram=%h, want all 0",
               count_w, count_r, disp_out, ram_out);
    end
    for (int i = 0; i < 16; i++) do_write(4'hF);
    vectors++;
    if (full !== 1'b1 || count_w !== 4'd0 || empty !== 1'b0) begin
      miscompares++;
      $display("FAIL fill16: got full=%b cw=%0d empty=%b, want full=1 cw=0 empty=0", full, count_w, empty);
    end
    do_write(4'h1);
    vectors++;
    if (full !== 1'b1 || count_w !== 4'd0) begin
      miscompares++;
      $display("FAIL write_when_full: got full=%b cw=%0d, want full=1 cw=0", full, count_w);
    end
    for (int i = 0; i < 16; i++) begin
      do_read();
      vectors++;
      if (ram_out !== 4'hF) begin
        miscompares++;
        $display("FAIL drain_data[%0d]: got ram=%h, want F", i, ram_out);
      end
    end
    vectors++;
    if (disp_out !== 12'h0F0 || count_r !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL drain16: got disp=%h cr=%0d e=%b f=%b, want disp=0F0 cr=0 e=1 f=0",
               disp_out, count_r, empty, full);
    end
  endtask

  task automatic test_simultaneous();
    do_clr();
    @(negedge clk);
    sw = 4'h7;
    key_wr_n = 1'b0;
    key_rd_n = 1'b0;
    @(negedge clk);
    key_wr_n = 1'b1;
    key_rd_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (ram_out !== 4'h7 || disp_out !== 12'h000 || count_w !== 4'd1) begin
      miscompares++;
      $display("FAIL simul_ram: got ram=%h disp=%h cw=%0d, want ram=7 disp=000 cw=1", ram_out, disp_out, count_w);
    end
    @(negedge clk);
    vectors++;
    if (disp_out !== 12'h007 || count_r !== 4'd1 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_disp: got disp=%h cr=%0d e=%b, want disp=007 cr=1 e=1", disp_out, count_r, empty);
    end
  endtask

  task automatic test_empty_read();
    do_read();
    vectors++;
    if (ram_out !== 4'h7 || disp_out !== 12'h007 || count_r !== 4'd1 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL read_empty: got ram=%h disp=%h cr=%0d e=%b, want ram=7 disp=007 cr=1 e=1",
               ram_out, disp_out, count_r, empty);
    end
    do_write(4'h2);
    @(negedge clk);
    key_rd_n = 1'b0;
    repeat (20) @(negedge clk);
    key_rd_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (ram_out !== 4'h2 || disp_out !== 12'h009 || count_r !== 4'd2 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL held_key_one_read: got ram=%h disp=%h cr=%0d e=%b, want ram=2 disp=009 cr=2 e=1",
               ram_out, disp_out, count_r, empty);
    end
  endtask

  task automatic test_back_to_back();
    do_clr();
    do_write(4'h4);
    @(negedge clk);
    key_rd_n = 1'b0;
    @(negedge clk);
    key_rd_n = 1'b1;
    sw = 4'h8;
    key_wr_n = 1'b0;
    @(negedge clk);
    key_wr_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (count_w !== 4'd1) begin
      miscompares++;
      $display("FAIL pend_wr_deferred: got cw=%0d, want 1", count_w);
    end
    @(negedge clk);
    vectors++;
    if (count_w !== 4'd2 || ram_out !== 4'h4 || disp_out !== 12'h004) begin
      miscompares++;
      $display("FAIL pend_wr_done: got cw=%0d ram=%h disp=%h, want cw=2 ram=4 disp=004",
               count_w, ram_out, disp_out);
    end
    do_read();
    vectors++;
    if (ram_out !== 4'h8 || disp_out !== 12'h00C || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL pend_wr_readback: got ram=%h disp=%h e=%b, want ram=8 disp=00C e=1",
               ram_out, disp_out, empty);
    end
  endtask

  task automatic test_clr_priority();
    do_clr();
    do_write(4'hB);
    @(negedge clk);
    clr = 1'b1;
    sw = 4'hC;
    key_wr_n = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    key_wr_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (count_w !== 4'd0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_priority: got cw=%0d e=%b, want cw=0 e=1", count_w, empty);
    end
  endtask

  task automatic test_reset_mid_read();
    do_clr();
    do_write(4'hA);
    @(negedge clk);
    key_rd_n = 1'b0;
    @(negedge clk);
    key_rd_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({count_w, count_r, ram_out, disp_out, empty, full} !== {4'h0, 4'h0, 4'h0, 12'h000, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_read: got cw=%h cr=%h ram=%h disp=%h e=%b f=%b, want all 0 e=1 f=0",
               count_w, count_r, ram_out, disp_out, empty, full);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_write(4'h5);
    do_read();
    vectors++;
    if (ram_out !== 4'h5 || disp_out !== 12'h005 || count_r !== 4'd1) begin
      miscompares++;
      $display("FAIL after_reset_read: got ram=%h disp=%h cr=%0d, want ram=5 disp=005 cr=1",
               ram_out, disp_out, count_r);
    end
  endtask

  task automatic test_acc_overflow();
    logic [11:0] exp1, exp2;
`ifdef ACC_SAT_EN
    exp1 = 12'hFFF;
    exp2 = 12'hFFF;
`else
    exp1 = 12'h001;
    exp2 = 12'h002;
`endif
    do_clr();
    // 17 rounds of 16 x F reach 4080; a final E brings the sum to FFE.
    for (int r = 0; r < 17; r++) begin
      for (int i = 0; i < 16; i++) do_write(4'hF);
      for (int i = 0; i < 16; i++) do_read();
    end
    do_write(4'hE);
    do_read();
    vectors++;
    if (disp_out !== 12'hFFE) begin
      miscompares++;
      $display("FAIL acc_near_top: got disp=%h, want FFE", disp_out);
    end
    do_write(4'h3);
    do_read();
    vectors++;
    if (disp_out !== exp1) begin
      miscompares++;
      $display("FAIL acc_overflow: got disp=%h, want %h", disp_out, exp1);
    end
    do_write(4'h1);
    do_read();
    vectors++;
    if (disp_out !== exp2) begin
      miscompares++;
      $display("FAIL acc_after_overflow: got disp=%h, want %h", disp_out, exp2);
    end
    do_clr();
    vectors++;
    if (disp_out !== 12'h000 || count_w !== 4'd0 || count_r !== 4'd0) begin
      miscompares++;
      $display("FAIL acc_clr: got disp=%h cw=%0d cr=%0d, want 000 0 0", disp_out, count_w, count_r);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    key_wr_n = 1'b1;
    key_rd_n = 1'b1;
    clr      = 1'b0;
    sw       = 4'h0;
    test_reset();
    test_basic();
    test_full_wrap();
    test_simultaneous();
    test_empty_read();
    test_back_to_back();
    test_clr_priority();
    test_reset_mid_read();
    test_acc_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
